timing_program_loader: RTL and testbench



---
 rtl/timing_program_loader.sv | 190 +++++++++++++++++++
 tb/tb_timing_program_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_program_loader.sv
// Assembles a 32-byte timing program from a host byte stream and presents it to the receiver with a widened RCV strobe.
// Optional 8-bit modular checksum byte after the data is enabled with `define LOADER_CRC_EN.
module timing_program_loader #(
  parameter logic [7:0]  HDR_BYTE  = 8'hA5,
  parameter int          RCV_LEN   = 8,
  parameter int          GUARD_LEN = 8,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] TNO,
  output logic [31:0] TOBM,
  output logic [31:0] TNC,
  output logic [31:0] TNI,
  output logic [31:0] TKI,
  output logic [31:0] TNP,
  output logic [31:0] TKP,
  output logic [31:0] CMND,
  output logic        RCV,
  output logic        busy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef LOADER_CRC_EN
    S_CHK,
`endif
    S_COMMIT,
    S_STROBE,
    S_GUARD
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_DROP     = 2'd3;

  state_t      state, state_d;
  logic [4:0]  bc, bc_d;
  logic [7:0]  sum, sum_d;
  logic [15:0] gap, gap_d;
  logic [7:0]  cnt, cnt_d;
  logic [31:0] shadow   [8];
  logic [31:0] shadow_d [8];
  logic [31:0] words    [8];
  logic        ok_d, err_d, load_words;
  logic [1:0]  code_d;
  logic        accept;

  assign in_ready = !(state inside {S_COMMIT, S_STROBE, S_GUARD});
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  assign TNO  = words[0];
  assign TOBM = words[1];
  assign TNC  = words[2];
  assign TNI  = words[3];
  assign TKI  = words[4];
  assign TNP  = words[5];
  assign TKP  = words[6];
  assign CMND = words[7];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state;
    bc_d     = bc;
    sum_d    = sum;
    gap_d    = '0;
    cnt_d    = cnt;
    shadow_d = shadow;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = err_code;

    if (in_valid && !in_ready) begin
      err_d  = 1'b1;
      code_d = ERR_DROP;
    end

    case (state)
      S_IDLE: begin
        if (accept && in_data == HDR_BYTE) begin
          state_d  = S_DATA;
          bc_d     = '0;
          sum_d    = '0;
          shadow_d = '{default: '0};
        end
      end
      S_DATA: begin
        if (accept) begin
          shadow_d[bc[4:2]] = {shadow[bc[4:2]][23:0], in_data};
          sum_d             = sum + in_data;
          bc_d              = bc + 5'd1;
          if (bc == 5'd31) begin
`ifdef LOADER_CRC_EN
            state_d = S_CHK;
`else
            state_d = S_COMMIT;
`endif
          end
        end
      end
`ifdef LOADER_CRC_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == sum) begin
            state_d = S_COMMIT;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_COMMIT: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt == 8'(RCV_LEN - 1)) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_GUARD: begin
        if (cnt == 8'(GUARD_LEN - 1)) state_d = S_IDLE;
        else                          cnt_d   = cnt + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap watchdog; an accept in the same clock always wins over the timeout.
    if (in_ready && state != S_IDLE && !accept) begin
      if (gap == TIMEOUT) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = S_IDLE;
      end else begin
        gap_d = gap + 16'd1;
      end
    end

    // Words are presented during the COMMIT clock, one clock ahead of RCV.
    load_words = (state_d == S_COMMIT) && (state != S_COMMIT);
    if (load_words) begin
      ok_d   = 1'b1;
      code_d = 2'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bc        <= '0;
      sum       <= '0;
      gap       <= '0;
      cnt       <= '0;
      // NOTE: the small shadow array is reset with everything else; the header clears it again anyway.
      shadow    <= '{default: '0};
      words     <= '{default: 32'hFFFF_FFFF};
      RCV       <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_d;
      bc        <= bc_d;
      sum       <= sum_d;
      gap       <= gap_d;
      cnt       <= cnt_d;
      shadow    <= shadow_d;
      if (load_words) words <= shadow_d;
      RCV       <= (state_d == S_STROBE);
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
    end
  end

endmodule

// File: tb/tb_timing_program_loader.sv
// Directed/randomised bench for timing_program_loader: frames are built from word values and
// the expected outputs come from a frame-level model (committed words, last error cause).
module tb_timing_program_loader;

  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         RCV_LEN   = 8;
  localparam int         GUARD_LEN = 8;
  localparam int         TIMEOUT   = 50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] tno, tobm, tnc, tni, tki, tnp, tkp, cmnd;
  logic        rcv, busy, frame_ok, frame_err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_words [8];
  logic [1:0]  model_code;

  always #5 clk = ~clk;

  timing_program_loader #(
    .HDR_BYTE (HDR),
    .RCV_LEN  (RCV_LEN),
    .GUARD_LEN(GUARD_LEN),
    .TIMEOUT  (16'(TIMEOUT))
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .TNO      (tno),
    .TOBM     (tobm),
    .TNC      (tnc),
    .TNI      (tni),
    .TKI      (tki),
    .TNP      (tnp),
    .TKP      (tkp),
    .CMND     (cmnd),
    .RCV      (rcv),
    .busy     (busy),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  function automatic logic [31:0] out_word(input int i);
    case (i)
      0:       return tno;
      1:       return tobm;
      2:       return tnc;
      3:       return tni;
      4:       return tki;
      5:       return tnp;
      6:       return tkp;
      default: return cmnd;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_w%0d", tag, i), out_word(i), model_words[i]);
  endtask

  function automatic int words_differ();
    int n = 0;
    for (int i = 0; i < 8; i++) if (out_word(i) !== model_words[i]) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
  endtask

  // Header, 32 big-endian data bytes, and (checksum builds only) sum + cs_delta.
  task automatic send_frame(input logic [31:0] w [8], input int cs_delta);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    send_byte(HDR, $urandom_range(0, 2));
    for (int i = 0; i < 8; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b   = w[i][8*k +: 8];
        sum = sum + b;
        send_byte(b, $urandom_range(0, 2));
      end
    end
`ifdef LOADER_CRC_EN
    send_byte(8'(sum + cs_delta), $urandom_range(0, 2));
`else
    if (cs_delta != 0) sum = sum + 8'(cs_delta);
`endif
  endtask

  // Watches one committed frame from the clock after its last byte until busy drops.
  task automatic observe_commit(input string tag, input int drop_at, input int rst_at);
    int fok_at = -1, rcv_first = -1, rcv_cnt = 0, nready = 0, n_ok = 0, n_err = 0, wbad = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (frame_ok) begin
        n_ok++;
        if (fok_at < 0) fok_at = cyc;
      end
      if (rcv) begin
        rcv_cnt++;
        if (rcv_first < 0) rcv_first = cyc;
      end
      if (!in_ready) nready++;
      if (frame_err) n_err++;
      wbad += words_differ();
      if (rst_at > 0 && rcv_cnt == rst_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_words = '{default: 32'hFFFF_FFFF};
        check({tag, "_rst_rcv"}, 32'(rcv), 32'd0);
        check_words({tag, "_rst"});
        return;
      end
      in_valid = (cyc == drop_at);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_fok_at"}, fok_at, 0);
    check({tag, "_fok_n"}, n_ok, 1);
    check({tag, "_rcv_first"}, rcv_first, 1);
    check({tag, "_rcv_len"}, rcv_cnt, RCV_LEN);
    check({tag, "_nready"}, nready, 1 + RCV_LEN + GUARD_LEN);
    check({tag, "_word_hold"}, wbad, 0);
    check({tag, "_err_n"}, n_err, (drop_at >= 0) ? 1 : 0);
    check({tag, "_code"}, 32'(err_code), 32'(model_code));
    check_words({tag, "_final"});
  endtask

  function automatic void rand_words(output logic [31:0] w [8]);
    for (int i = 0; i < 8; i++) w[i] = $urandom;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [8];
    int waited;
    bit seen;

    model_words = '{default: 32'hFFFF_FFFF};
    model_code  = 2'd0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_rcv", 32'(rcv), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_words("idle");
    check("idle_rcv", 32'(rcv), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ok", 32'(frame_ok), 32'd0);
    check("idle_err", 32'(frame_err), 32'd0);
    check("idle_code", 32'(err_code), 32'd0);

    // Directed frame.
    w = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0005, 32'h0000_0030,
          32'h0000_0040, 32'h0000_0050, 32'h0000_0060, 32'h1234_FFFF};
    send_frame(w, 0);
    model_words = w;
    model_code  = 2'd0;
    observe_commit("dir", -1, 0);

`ifdef LOADER_CRC_EN
    // Wrong checksum: error, old words kept, no strobe.
    rand_words(w);
    send_frame(w, 1);
    @(negedge clk);
    in_valid   = 1'b0;
    model_code = 2'd2;
    check("cs_err", 32'(frame_err), 32'd1);
    check("cs_code", 32'(err_code), 32'(model_code));
    check("cs_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rcv || frame_ok) seen = 1'b1;
    end
    check("cs_no_rcv", 32'(seen), 32'd0);
    check_words("cs_hold");
`endif

    // Header plus 10 bytes, then silence until the gap watchdog fires.
    send_byte(HDR, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    waited = 0;
    seen   = 1'b0;
    while (waited < TIMEOUT + 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      waited++;
      if (frame_err) begin
        seen = 1'b1;
        break;
      end
    end
    model_code = 2'd1;
    check("to_seen", 32'(seen), 32'd1);
    check("to_window", 32'(waited >= TIMEOUT && waited <= TIMEOUT + 3), 32'd1);
    check("to_code", 32'(err_code), 32'(model_code));
    @(negedge clk);
    check("to_idle", 32'(busy), 32'd0);
    check_words("to_hold");

    rand_words(w);
    send_frame(w, 0);
    model_words = w;
    model_code  = 2'd0;
    observe_commit("after_to", -1, 0);

    // Leading junk is discarded silently.
    send_byte(8'h00, 1);
    send_byte(8'h7E, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("junk_busy", 32'(busy), 32'd0);
    check("junk_err", 32'(frame_err), 32'd0);
    rand_words(w);
    send_frame(w, 0);
    model_words = w;
    observe_commit("junk", -1, 0);

    // Byte offered during the strobe is dropped; the strobe still completes.
    rand_words(w);
    send_frame(w, 0);
    model_words = w;
    model_code  = 2'd3;
    observe_commit("drop", 3, 0);

    // Reset during the third RCV clock.
    rand_words(w);
    send_frame(w, 0);
    model_words = w;
    observe_commit("midrst", -1, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_code", 32'(err_code), 32'd0);
    check_words("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
